// File: rtl/fill_drain_ctrl.sv
// Fill/drain phase controller: drives the three water valves for one fill or
// drain operation, with debounced level sensing, timeout, door pause and abort.
module fill_drain_ctrl #(
  parameter int FILL_TIMEOUT  = 40,
  parameter int DRAIN_TIMEOUT = 30,
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             level_full,
  input  logic             level_empty,
  input  logic             doorclosed,
  input  logic             abort,
  output logic             valve_in_cold,
  output logic             valve_in_hot,
  output logic             valve_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] elapsed
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_COLD  = 2'b01;
  localparam logic [1:0] OP_HOT   = 2'b10;
  localparam logic [1:0] OP_DRAIN = 2'b11;

  localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_DRAIN  = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] settle_q, settle_d;

  logic             is_drain;
  logic             sensor;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] elapsed_inc;

  assign is_drain    = (op_q == OP_DRAIN);
  assign sensor      = is_drain ? level_empty : level_full;
  assign limit       = is_drain ? DRAIN_LAST : FILL_LAST;
  assign elapsed_inc = (elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      elapsed_q <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      elapsed_q <= elapsed_d;
      settle_q  <= settle_d;
    end
  end

  // Abort beats a door opening, which beats completion, which beats timeout.
  // Only a cycle that actually runs with the door shut advances the counters.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    elapsed_d = elapsed_q;
    settle_d  = settle_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && (cmd_op != OP_NONE)) begin
          op_d      = cmd_op;
          elapsed_d = '0;
          settle_d  = '0;
          state_d   = (cmd_op == OP_DRAIN) ? S_DRAIN : S_FILL;
        end
      end
      S_FILL, S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!doorclosed) begin
          state_d  = S_PAUSED;
          settle_d = '0;
        end else begin
          elapsed_d = elapsed_inc;
          settle_d  = sensor ? settle_q + 1'b1 : '0;
          if (sensor && (settle_q == SETTLE_LAST)) begin
            state_d = S_DONE;
          end else if (elapsed_q == limit) begin
            state_d = S_ERROR;
          end
        end
      end
      S_PAUSED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (doorclosed) begin
          state_d = is_drain ? S_DRAIN : S_FILL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (abort) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q == S_FILL) || (state_q == S_DRAIN) || (state_q == S_PAUSED);
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERROR);
  assign valve_in_cold = (state_q == S_FILL) && (op_q == OP_COLD);
  assign valve_in_hot  = (state_q == S_FILL) && (op_q == OP_HOT);
  assign valve_out     = (state_q == S_DRAIN);
  assign elapsed       = elapsed_q;

endmodule

// File: tb/tb_fill_drain_ctrl.sv
// Bench for fill_drain_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against an operation-level model.
module tb_fill_drain_ctrl;

  localparam int FILL_TO  = 40;
  localparam int DRAIN_TO = 30;
  localparam int SETTLE   = 3;
  localparam int W        = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic         cmd_ready;
  logic         level_full;
  logic         level_empty;
  logic         doorclosed;
  logic         abort;
  logic         valve_in_cold;
  logic         valve_in_hot;
  logic         valve_out;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] elapsed;

  int checks = 0;
  int errors = 0;

  bit model_valid = 1'b0;
  int m_op        = 0;
  bit m_paused    = 1'b0;
  bit m_done      = 1'b0;
  bit m_err       = 1'b0;
  int m_elapsed   = 0;
  int m_streak    = 0;

  always #5 clk = ~clk;

  fill_drain_ctrl #(
    .FILL_TIMEOUT (FILL_TO),
    .DRAIN_TIMEOUT(DRAIN_TO),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_ready    (cmd_ready),
    .level_full   (level_full),
    .level_empty  (level_empty),
    .doorclosed   (doorclosed),
    .abort        (abort),
    .valve_in_cold(valve_in_cold),
    .valve_in_hot (valve_in_hot),
    .valve_out    (valve_out),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .elapsed      (elapsed)
  );

  function automatic bit targetLevel(input int op);
    return (op == 3) ? level_empty : level_full;
  endfunction

  function automatic int timeoutFor(input int op);
    return (op == 3) ? DRAIN_TO : FILL_TO;
  endfunction

  // Operation-level model: m_op is the running operation (0 = none), m_streak
  // counts consecutive target-sensor highs, m_elapsed counts running cycles.
  always @(posedge clk) begin
    if (rst) begin
      model_valid <= 1'b1;
      m_op        <= 0;
      m_paused    <= 1'b0;
      m_done      <= 1'b0;
      m_err       <= 1'b0;
      m_elapsed   <= 0;
      m_streak    <= 0;
    end else if (model_valid) begin
      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_err) begin
        if (abort) m_err <= 1'b0;
      end else if (m_op == 0) begin
        if (cmd_valid && cmd_op != 2'b00) begin
          m_op      <= int'(cmd_op);
          m_elapsed <= 0;
          m_streak  <= 0;
          m_paused  <= 1'b0;
        end
      end else if (abort) begin
        m_op     <= 0;
        m_paused <= 1'b0;
      end else if (m_paused) begin
        if (doorclosed) m_paused <= 1'b0;
      end else if (!doorclosed) begin
        m_paused <= 1'b1;
        m_streak <= 0;
      end else begin
        m_elapsed <= (m_elapsed < 255) ? m_elapsed + 1 : 255;
        m_streak  <= targetLevel(m_op) ? m_streak + 1 : 0;
        if (targetLevel(m_op) && (m_streak + 1 >= SETTLE)) begin
          m_op   <= 0;
          m_done <= 1'b1;
        end else if (m_elapsed + 1 >= timeoutFor(m_op)) begin
          m_op  <= 0;
          m_err <= 1'b1;
        end
      end
    end
  end

  task automatic checkOne(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic checkOutput();
    bit running;
    running = (m_op != 0) && !m_paused;
    checkOne("cmd_ready", int'(cmd_ready), int'(m_op == 0 && !m_done && !m_err));
    checkOne("busy", int'(busy), int'(m_op != 0));
    checkOne("valve_in_cold", int'(valve_in_cold), int'(running && m_op == 1));
    checkOne("valve_in_hot", int'(valve_in_hot), int'(running && m_op == 2));
    checkOne("valve_out", int'(valve_out), int'(running && m_op == 3));
    checkOne("done", int'(done), int'(m_done));
    checkOne("error", int'(error), int'(m_err));
    checkOne("elapsed", int'(elapsed), m_elapsed);
  endtask

  always @(negedge clk) begin
    if (model_valid) checkOutput();
  end

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic full,
                               input logic empty, input logic door, input logic ab,
                               input logic r);
    cmd_valid   = v;
    cmd_op      = op;
    level_full  = full;
    level_empty = empty;
    doorclosed  = door;
    abort       = ab;
    rst         = r;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Bit i of sens / door_open applies to the i-th cycle after acceptance; the
  // non-target sensor and cmd inputs are randomized since they must be ignored.
  task automatic runPattern(input logic [1:0] op, input logic [63:0] sens,
                            input logic [63:0] door_open, input int abort_at,
                            input int probe_at, output int valve_cyc,
                            output bit saw_done, output bit saw_err,
                            output int probe_elapsed, output int probe_valve);
    logic other;
    valve_cyc     = 0;
    saw_done      = 1'b0;
    saw_err       = 1'b0;
    probe_elapsed = -1;
    probe_valve   = -1;
    applyStimulus(1'b1, op, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (done) saw_done = 1'b1;
      if (error) saw_err = 1'b1;
      if (done || error || cmd_ready) break;
      if (valve_in_cold || valve_in_hot || valve_out) valve_cyc++;
      if (i == probe_at) begin
        probe_elapsed = int'(elapsed);
        probe_valve   = int'(valve_in_cold || valve_in_hot || valve_out);
      end
      other = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    (op == 2'b11) ? other : sens[i], (op == 2'b11) ? sens[i] : other,
                    !door_open[i], (i == abort_at), 1'b0);
    end
  endtask

  initial begin
    int  vc, pe, pv;
    bit  sd, se;
    logic lf, le;
    int  rate;

    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOne("reset_cmd_ready", int'(cmd_ready), 1);
    checkOne("reset_elapsed", int'(elapsed), 0);
    idleCycle();

    $display("[TB] fill cold, level_full from 6th cycle");
    runPattern(2'b01, 64'hFFFF_FFFF_FFFF_FFE0, 64'h0, -1, -1, vc, sd, se, pe, pv);
    checkOne("t1_valve_cycles", vc, 8);
    checkOne("t1_done_seen", int'(sd), 1);
    checkOne("t1_elapsed", int'(elapsed), 8);
    idleCycle();
    checkOne("t1_done_one_cycle", int'(done), 0);
    checkOne("t1_elapsed_kept", int'(elapsed), 8);

    $display("[TB] drain timeout then abort");
    runPattern(2'b11, 64'h0, 64'h0, -1, -1, vc, sd, se, pe, pv);
    checkOne("t2_valve_cycles", vc, 30);
    checkOne("t2_error_seen", int'(se), 1);
    checkOne("t2_elapsed", int'(elapsed), 30);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOne("t2_error_sticky", int'(error), 1);
    checkOne("t2_ready_in_error", int'(cmd_ready), 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOne("t2_error_cleared", int'(error), 0);
    checkOne("t2_ready_after_abort", int'(cmd_ready), 1);

    $display("[TB] fill hot with door pause");
    runPattern(2'b10, 64'hFFFF_FFFF_FFFF_FFF0, 64'h3C0, -1, 8, vc, sd, se, pe, pv);
    checkOne("t3_paused_elapsed", pe, 6);
    checkOne("t3_paused_valve", pv, 0);
    checkOne("t3_valve_cycles", vc, 10);
    checkOne("t3_done_seen", int'(sd), 1);
    checkOne("t3_elapsed", int'(elapsed), 9);
    idleCycle();

    $display("[TB] fill with level glitch");
    runPattern(2'b01, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0, -1, -1, vc, sd, se, pe, pv);
    checkOne("t4_valve_cycles", vc, 6);
    checkOne("t4_done_seen", int'(sd), 1);
    idleCycle();

    $display("[TB] completion on the timeout cycle");
    runPattern(2'b01, 64'hFFFF_FFE0_0000_0000, 64'h0, -1, -1, vc, sd, se, pe, pv);
    checkOne("t5_done_seen", int'(sd), 1);
    checkOne("t5_error_seen", int'(se), 0);
    checkOne("t5_elapsed", int'(elapsed), 40);
    idleCycle();

    $display("[TB] abort together with completion");
    runPattern(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2, -1, vc, sd, se, pe, pv);
    checkOne("t6_done_seen", int'(sd), 0);
    checkOne("t6_valve_cycles", vc, 3);

    $display("[TB] reset mid-drain and null command");
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    checkOne("t7_draining", int'(valve_out), 1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOne("t7_valve_dropped", int'(valve_out), 0);
    checkOne("t7_elapsed_reset", int'(elapsed), 0);
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOne("t7_null_cmd_ready", int'(cmd_ready), 1);
    checkOne("t7_null_cmd_busy", int'(busy), 0);

    $display("[TB] randomized traffic");
    lf = 1'b0;
    le = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      rate = ((n / 250) % 2 == 1) ? 63 : 5;
      if ($urandom_range(0, rate) == 0) lf = ~lf;
      if ($urandom_range(0, rate) == 0) le = ~le;
      applyStimulus(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), lf, le,
                    1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 59) == 0),
                    1'($urandom_range(0, 299) == 0));
    end
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
